vendo_coin_cond: RTL and testbench



---
 rtl/vendo_coin_cond_pkg.sv | 16 +
 rtl/vendo_coin_debounce.sv | 93 +++++++++
 rtl/vendo_coin_cond.sv | 64 ++++++
 tb/tb_vendo_coin_cond.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vendo_coin_cond_pkg.sv
// Shared channel-state encoding and default timing parameters for the vendo_2p coin conditioner.
package vendo_coin_cond_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DEB_PRESS = 3'd1,
      PRESSED   = 3'd2,
      DEB_REL   = 3'd3,
      JAM       = 3'd4
   } ch_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_JAM_CYCLES      = 64;
   localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/vendo_coin_debounce.sv
// One coin channel: 2-flop synchroniser, press/release debounce FSM and jam timer.
// qualify is a one-cycle strobe on the edge the press qualifies (DEBOUNCE_CYCLES+2 after first low sample); no backpressure.
module vendo_coin_debounce
   import vendo_coin_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int JAM_CYCLES      = DEF_JAM_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic qualify,
   output logic in_jam
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   ch_state_t        state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         case (state)
            IDLE: begin
               if (!sync2) begin
                  state <= DEB_PRESS;
                  cnt   <= '0;
               end
            end
            DEB_PRESS: begin
               if (sync2) begin
                  state <= IDLE;
               end else if (cnt == DEB_LAST) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (sync2) begin
                  state <= DEB_REL;
                  cnt   <= '0;
               end else if (cnt == JAM_LAST) begin
                  state <= JAM;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DEB_REL: begin
               // A release bounce restarts the jam timer but never re-credits.
               if (!sync2) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            JAM: begin
               if (!sync2) begin
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign qualify = (state == DEB_PRESS) && !sync2 && (cnt == DEB_LAST);
   assign in_jam  = (state == JAM);

endmodule

// File: rtl/vendo_coin_cond.sv
// Conditions raw 1P/5P sensors into one-cycle active-low credit pulses (DEBOUNCE_CYCLES+3 clocks latency).
// Simultaneous credits are serialised 1P first through depth-1 pending flags; p1/p5 never low together.
module vendo_coin_cond
   import vendo_coin_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int JAM_CYCLES      = DEF_JAM_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic coin1_raw,
   input  logic coin5_raw,
   output logic p1,
   output logic p5,
   output logic jam
);

   logic qual1, qual5;
   logic jam1, jam5;
   logic pend1, pend5;

   vendo_coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .JAM_CYCLES      (JAM_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch1 (
      .clk     (clk),
      .reset   (reset),
      .raw     (coin1_raw),
      .qualify (qual1),
      .in_jam  (jam1)
   );

   vendo_coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .JAM_CYCLES      (JAM_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch5 (
      .clk     (clk),
      .reset   (reset),
      .raw     (coin5_raw),
      .qualify (qual5),
      .in_jam  (jam5)
   );

   // pend1 is always serviced the edge after it is set; pend5 waits while pend1 owns the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend1 <= 1'b0;
         pend5 <= 1'b0;
         p1    <= 1'b1;
         p5    <= 1'b1;
         jam   <= 1'b0;
      end else begin
         p1    <= !pend1;
         p5    <= !(pend5 && !pend1);
         pend1 <= qual1;
         pend5 <= qual5 || (pend5 && pend1);
         jam   <= jam1 || jam5;
      end
   end

endmodule

// File: tb/tb_vendo_coin_cond.sv
// Directed bench for vendo_coin_cond: pulse timing, bounce rejection, arbitration, jam and async reset.
module tb_vendo_coin_cond;

   logic clk = 1'b0;
   logic reset;
   logic coin1_raw;
   logic coin5_raw;
   logic p1, p5, jam;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int p1_cnt, p5_cnt, both_cnt, p1_last, p5_last, jam_rise, jam_fall;
   logic jam_prev = 1'b0;
   int e0;

   vendo_coin_cond dut (
      .clk       (clk),
      .reset     (reset),
      .coin1_raw (coin1_raw),
      .coin5_raw (coin5_raw),
      .p1        (p1),
      .p5        (p5),
      .jam       (jam)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Output observer: one sample per cycle, on the falling edge.
   always @(negedge clk) begin
      if (p1 === 1'b0) begin
         p1_cnt  = p1_cnt + 1;
         p1_last = cyc;
      end
      if (p5 === 1'b0) begin
         p5_cnt  = p5_cnt + 1;
         p5_last = cyc;
      end
      if (p1 === 1'b0 && p5 === 1'b0) both_cnt = both_cnt + 1;
      if (jam === 1'b1 && jam_prev === 1'b0 && jam_rise < 0) jam_rise = cyc;
      if (jam === 1'b0 && jam_prev === 1'b1 && jam_fall < 0) jam_fall = cyc;
      jam_prev = jam;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      p1_cnt   = 0;
      p5_cnt   = 0;
      both_cnt = 0;
      p1_last  = -1;
      p5_last  = -1;
      jam_rise = -1;
      jam_fall = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      clr_mon();
      reset     = 1'b1;
      coin1_raw = 1'b1;
      coin5_raw = 1'b1;

      // 1: reset values and quiet idle
      idle(3);
      check("rst_p1", {31'd0, p1}, 32'd1);
      check("rst_p5", {31'd0, p5}, 32'd1);
      check("rst_jam", {31'd0, jam}, 32'd0);
      reset = 1'b0;
      clr_mon();
      idle(20);
      check("idle_p1_cnt", p1_cnt, 0);
      check("idle_p5_cnt", p5_cnt, 0);
      check("idle_jam", {31'd0, jam}, 32'd0);

      // 2: clean 1P press, 10 low samples
      clr_mon();
      coin1_raw = 1'b0;
      e0 = cyc + 1;
      idle(10);
      coin1_raw = 1'b1;
      idle(20);
      check("t2_p1_cnt", p1_cnt, 1);
      check("t2_p1_time", p1_last, e0 + 7);
      check("t2_p5_cnt", p5_cnt, 0);

      // 3: 5P glitch rejected, then bouncy press accepted once
      clr_mon();
      coin5_raw = 1'b0;
      idle(3);
      coin5_raw = 1'b1;
      idle(10);
      check("t3_glitch_p5", p5_cnt, 0);
      clr_mon();
      coin5_raw = 1'b0;
      e0 = cyc + 1;
      idle(2);
      coin5_raw = 1'b1;
      idle(1);
      coin5_raw = 1'b0;
      idle(12);
      coin5_raw = 1'b1;
      idle(25);
      check("t3_bounce_p5_cnt", p5_cnt, 1);
      check("t3_bounce_p5_time", p5_last, e0 + 10);
      check("t3_p1_cnt", p1_cnt, 0);

      // 4: simultaneous press, 1P first then 5P
      clr_mon();
      coin1_raw = 1'b0;
      coin5_raw = 1'b0;
      e0 = cyc + 1;
      idle(10);
      coin1_raw = 1'b1;
      coin5_raw = 1'b1;
      idle(20);
      check("t4_p1_cnt", p1_cnt, 1);
      check("t4_p5_cnt", p5_cnt, 1);
      check("t4_p1_time", p1_last, e0 + 7);
      check("t4_p5_time", p5_last, e0 + 8);
      check("t4_both_low", both_cnt, 0);

      // 5: 1P held 100 cycles -> jam, then release
      clr_mon();
      coin1_raw = 1'b0;
      e0 = cyc + 1;
      idle(100);
      check("t5_jam_high", {31'd0, jam}, 32'd1);
      coin1_raw = 1'b1;
      idle(20);
      check("t5_p1_cnt", p1_cnt, 1);
      check("t5_p1_time", p1_last, e0 + 7);
      check("t5_jam_rise", jam_rise, e0 + 71);
      check("t5_jam_fall", jam_fall, e0 + 106);
      check("t5_jam_low", {31'd0, jam}, 32'd0);

      // 6: reset while the qualified 1P credit is pending
      clr_mon();
      coin1_raw = 1'b0;
      idle(7);
      reset = 1'b1;
      coin1_raw = 1'b1;
      #1;
      check("t6_p1_async", {31'd0, p1}, 32'd1);
      check("t6_jam_async", {31'd0, jam}, 32'd0);
      idle(3);
      reset = 1'b0;
      idle(20);
      check("t6_p1_cnt", p1_cnt, 0);
      check("t6_p5_cnt", p5_cnt, 0);

      // 7: reset during a 5P jam clears jam without waiting for a clock
      clr_mon();
      coin5_raw = 1'b0;
      e0 = cyc + 1;
      idle(76);
      check("t7_jam_high", {31'd0, jam}, 32'd1);
      check("t7_p5_cnt", p5_cnt, 1);
      #2;
      reset = 1'b1;
      #1;
      check("t7_jam_async", {31'd0, jam}, 32'd0);
      check("t7_p5_async", {31'd0, p5}, 32'd1);
      coin5_raw = 1'b1;
      idle(3);
      reset = 1'b0;
      clr_mon();
      idle(20);
      check("t7_post_p5_cnt", p5_cnt, 0);
      check("t7_post_jam", {31'd0, jam}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
